// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and fetch FSM encoding shared by
// instr_fetch_unit, control_unit and the downstream datapath.
package cpu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_JUMP  = 3'b100;

    // 16-bit layout: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2,
    // [6:0] imm (overlaps rs2), [12:0] jump target
    localparam int FIELD_W    = 3;
    localparam int OPCODE_LSB = 13;
    localparam int RD_LSB     = 10;
    localparam int RS1_LSB    = 7;
    localparam int RS2_LSB    = 4;
    localparam int IMM_W      = 7;
    localparam int TGT_W      = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with next-PC select (jump target or wrapping increment).
//   clk, rst_n : clock, async active-low reset (loads RESET_PC)
//   advance    : update the PC this cycle (issue handshake)
//   jump       : take target instead of pc+1
//   target     : jump destination
//   pc         : current fetch address
module pc_reg #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            jump,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    // Increment wraps naturally at 2^PC_W
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            pc <= RESET_PC;
        else if (advance)
            pc <= jump ? target : pc + PC_W'(1);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one word at a time over imem req/ack,
// holds it in the instruction register and exposes its decoded fields.
//   run                      : permit fetching; 0 lets the current fetch finish, then holds
//   imem_req/addr/ack/rdata  : instruction memory handshake (ack legal in first FETCH cycle)
//   instr_valid/instr_ready  : issue handshake to execute/writeback
//   jump                     : control_unit Jump, sampled only on the issue handshake
//   opcode/rd/rs1/rs2/imm    : IR fields; jump_target = IR[12:0] sized to PC_W
//   pc                       : address of the instruction held in IR
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    output logic [2:0]         opcode,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [6:0]         imm,
    output logic [PC_W-1:0]    jump_target,
    output logic [PC_W-1:0]    pc
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    fetch_pc;
    logic               issue;

    assign issue = instr_valid & instr_ready;

    pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (issue),
        .jump    (jump),
        .target  (jump_target),
        .pc      (fetch_pc)
    );

    assign imem_addr   = fetch_pc;
    assign opcode      = ir[OPCODE_LSB +: FIELD_W];
    assign rd          = ir[RD_LSB +: FIELD_W];
    assign rs1         = ir[RS1_LSB +: FIELD_W];
    assign rs2         = ir[RS2_LSB +: FIELD_W];
    assign imm         = ir[0 +: IMM_W];
    assign jump_target = PC_W'(ir[0 +: TGT_W]);

    // imem_req and instr_valid are registered alongside the state so neither
    // has a combinational path from instr_ready or imem_ack.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            ir          <= '0;
            pc          <= RESET_PC;
        end else begin
            case (state)
                S_IDLE:
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                S_FETCH:
                    if (imem_ack) begin
                        state       <= S_ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        ir          <= imem_rdata;
                        pc          <= fetch_pc;
                    end
                S_ISSUE:
                    if (instr_ready) begin
                        state       <= run ? S_FETCH : S_IDLE;
                        imem_req    <= run;
                        instr_valid <= 1'b0;
                    end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a transaction-level program-flow model.
module tb_instr_fetch_unit;

    logic        clk, rst_n, run;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        instr_valid, instr_ready, jump;
    logic [2:0]  opcode, rd, rs1, rs2;
    logic [6:0]  imm;
    logic [7:0]  jump_target, pc;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [256];
    int          dly = 0;
    int          cnt = 0;
    bit          stray = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .jump(jump),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .jump_target(jump_target), .pc(pc)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Memory: acks once the request has been held for dly cycles; stray forces an ack.
    assign imem_ack   = (imem_req && cnt >= dly) || stray;
    assign imem_rdata = mem[imem_addr];
    always @(posedge clk) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;

    // control_unit stand-in: Jump for the JUMP opcode
    assign jump = (opcode == 3'b100);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Program-flow model: the next fetch address follows the issued stream.
    logic [7:0]  m_pc;
    logic [15:0] w;
    bit          hs_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc    = 8'h00;
            hs_prev = 0;
            chk("m_rst_req", imem_req, 0);
            chk("m_rst_valid", instr_valid, 0);
        end else begin
            w = mem[m_pc];
            chk("m_req_valid_excl", imem_req & instr_valid, 0);
            if (imem_req) chk("m_addr", imem_addr, m_pc);
            if (hs_prev) chk("m_valid_drop", instr_valid, 0);
            if (instr_valid) begin
                chk("m_pc", pc, m_pc);
                chk("m_opcode", opcode, w >> 13);
                chk("m_rd", rd, (w >> 10) & 16'h7);
                chk("m_rs1", rs1, (w >> 7) & 16'h7);
                chk("m_rs2", rs2, (w >> 4) & 16'h7);
                chk("m_imm", imm, w & 16'h7F);
                chk("m_target", jump_target, w & 16'hFF);
            end
            hs_prev = instr_valid && instr_ready;
            if (hs_prev) m_pc = ((w >> 13) == 16'd4) ? w[7:0] : m_pc + 8'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_at(input logic [7:0] a);
        int n = 0;
        while (!(instr_valid && pc == a) && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL wait_pc_%0h: no issue seen, got pc %0h expected %0h", a, pc, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] h_op, h_rd, h_rs1, h_rs2;
    logic [6:0] h_imm;
    int         n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {3'(i % 4), 13'(i * 37 + 5)};
        mem[0]     = 16'h0A91;
        mem[5]     = 16'h8023;
        mem[8'h24] = 16'h80FF;
        rst_n = 0; run = 0; instr_ready = 1;
        repeat (3) tick();
        chk("rst_opcode", opcode, 0);
        chk("rst_rd", rd, 0);
        chk("rst_imm", imm, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_req", imem_req, 0);
        rst_n = 1;
        tick();
        chk("idle_req", imem_req, 0);
        // Basic fetch, zero-wait memory, immediate ready
        run = 1;
        tick();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        tick();
        chk("t1_valid", instr_valid, 1);
        chk("t1_opcode", opcode, 0);
        chk("t1_rd", rd, 2);
        chk("t1_rs1", rs1, 5);
        chk("t1_rs2", rs2, 1);
        chk("t1_imm", imm, 7'h11);
        chk("t1_pc", pc, 0);
        tick();
        chk("t1_next_addr", imem_addr, 1);
        chk("t1_next_req", imem_req, 1);
        chk("t1_valid_low", instr_valid, 0);
        tick();
        chk("t1_valid2", instr_valid, 1);
        chk("t1_pc2", pc, 1);
        // Memory ack delayed by 3 cycles
        dly = 3;
        tick();
        n = 0;
        while (imem_req && n < 10) begin
            chk("t2_addr_hold", imem_addr, 2);
            n++;
            tick();
        end
        chk("t2_req_cycles", n, 4);
        chk("t2_valid", instr_valid, 1);
        chk("t2_pc", pc, 2);
        dly = 0;
        // Downstream stall for 5 cycles
        instr_ready = 0;
        h_op = opcode; h_rd = rd; h_rs1 = rs1; h_rs2 = rs2; h_imm = imm;
        repeat (5) begin
            tick();
            chk("t3_valid", instr_valid, 1);
            chk("t3_req", imem_req, 0);
            chk("t3_pc", pc, 2);
            chk("t3_fields", {opcode, rd, rs1, rs2, imm}, {h_op, h_rd, h_rs1, h_rs2, h_imm});
        end
        instr_ready = 1;
        tick();
        chk("t3_next_addr", imem_addr, 3);
        // Jump at 5 -> 0x23, jump at 0x24 -> 0xFF, then wrap to 0
        wait_valid_at(8'h05);
        chk("t4_opcode", opcode, 3'b100);
        chk("t4_target", jump_target, 8'h23);
        tick();
        chk("t4_jump_addr", imem_addr, 8'h23);
        wait_valid_at(8'hFF);
        tick();
        chk("t4_wrap_addr", imem_addr, 8'h00);
        chk("t4_wrap_req", imem_req, 1);
        // run dropped mid-fetch: fetch completes, issues, parks in IDLE
        run = 0;
        tick();
        chk("t5_valid", instr_valid, 1);
        chk("t5_pc", pc, 0);
        tick();
        chk("t5_idle_req", imem_req, 0);
        chk("t5_idle_valid", instr_valid, 0);
        chk("t5_pc_advanced", imem_addr, 1);
        stray = 1;
        tick();
        stray = 0;
        chk("t5_stray_rd", rd, 2);
        chk("t5_stray_imm", imm, 7'h11);
        chk("t5_stray_valid", instr_valid, 0);
        run = 1;
        tick();
        chk("t5_resume_req", imem_req, 1);
        chk("t5_resume_addr", imem_addr, 1);
        // Reset in the middle of a slow fetch
        dly = 5;
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_req", imem_req, 0);
        chk("t6_async_valid", instr_valid, 0);
        tick();
        run = 0;
        dly = 0;
        rst_n = 1;
        tick();
        stray = 1;
        tick();
        stray = 0;
        chk("t6_ir_opcode", opcode, 0);
        chk("t6_ir_rd", rd, 0);
        chk("t6_ir_rs1", rs1, 0);
        chk("t6_ir_imm", imm, 0);
        chk("t6_valid", instr_valid, 0);
        chk("t6_req", imem_req, 0);
        chk("t6_addr", imem_addr, 0);
        run = 1;
        tick();
        chk("t6_refetch_addr", imem_addr, 0);
        tick();
        chk("t6_refetch_rd", rd, 2);
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
